// File: rtl/npu_stream_sequencer.sv
// Stream sequencer between DMA beats and an NxN systolic core: packs input beats
// into core rows, throttles issue with result-buffer credits and unpacks result rows.
module npu_relu_lane #(
  parameter int W = 32
) (
  input  logic         relu,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  assign dout = (relu && din[W-1]) ? '0 : din;
endmodule

module npu_stream_sequencer #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int AXI_WIDTH  = 64,
  parameter int RES_DEPTH  = 32,
  parameter int LOAD_FLUSH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                mode,
  input  logic [31:0]               total_rows,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic [AXI_WIDTH-1:0]      dma_data_in,
  input  logic                      dma_data_in_valid,
  output logic                      dma_data_in_ready,
  output logic [AXI_WIDTH-1:0]      dma_data_out,
  output logic                      dma_data_out_valid,
  input  logic                      dma_data_out_ready,
  output logic                      dma_data_out_last,
  output logic                      core_load_weight,
  output logic [N-1:0]              core_valid_in,
  output logic [N*DATA_WIDTH-1:0]   core_x_in,
  output logic [N*ACC_WIDTH-1:0]    core_y_in,
  input  logic [N*ACC_WIDTH-1:0]    core_y_out,
  input  logic [N-1:0]              core_valid_out
);
  localparam int ROW_W     = N*DATA_WIDTH;
  localparam int RES_W     = N*ACC_WIDTH;
  localparam int IN_BEATS  = ROW_W/AXI_WIDTH;
  localparam int OUT_BEATS = RES_W/AXI_WIDTH;
  localparam int IBW = (IN_BEATS > 1)  ? $clog2(IN_BEATS)  : 1;
  localparam int OBW = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
  localparam int PW  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW  = $clog2(RES_DEPTH+1);
  localparam int FW  = $clog2(LOAD_FLUSH+1);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t            state, state_n;
  logic [1:0]        mode_q;
  logic [31:0]       total_q, rows_fed, rows_drained, drained_n;
  logic [IBW-1:0]    in_beat;
  logic [OBW-1:0]    out_beat;
  logic [ROW_W-1:0]  asm_q, row_n, x_q;
  logic              issue_q, load_q;
  logic [FW-1:0]     flush_cnt;
  logic [RES_W-1:0]  fifo_mem [RES_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt, credits;
  logic              exec, abort_act, in_fire, row_last, issue_dec;
  logic              cap, push, drop_err, out_fire, pop;
  logic [N-1:0][ACC_WIDTH-1:0] head, head_r;
  logic [RES_W-1:0]  head_flat;

  assign exec      = (mode_q != 2'd0);
  assign abort_act = abort && (state != S_IDLE);
  assign in_fire   = dma_data_in_valid && dma_data_in_ready;
  assign row_last  = in_fire && (in_beat == IBW'(IN_BEATS-1));
  assign issue_dec = issue_q && exec;
  assign cap       = &core_valid_out;
  // results landing while idle belong to an aborted job and vanish quietly
  assign push      = cap && exec && (state != S_IDLE) && !abort_act && (fifo_cnt != CW'(RES_DEPTH));
  assign drop_err  = (state != S_IDLE) && !abort_act &&
                     ((cap && exec && (fifo_cnt == CW'(RES_DEPTH))) || (|core_valid_out && !exec));
  assign dma_data_out_valid = (fifo_cnt != '0);
  assign out_fire  = dma_data_out_valid && dma_data_out_ready;
  assign pop       = out_fire && (out_beat == OBW'(OUT_BEATS-1));
  assign drained_n = rows_drained + {31'd0, pop};

  // a row already assembled but not yet issued still owns a credit
  assign dma_data_in_ready = (state == S_FEED) && (rows_fed < total_q) &&
                             ((mode_q == 2'd0) || (credits > CW'(issue_q)));

  always_comb begin
    row_n = asm_q;
    row_n[int'(in_beat)*AXI_WIDTH +: AXI_WIDTH] = dma_data_in;
  end

  assign head = fifo_mem[rd_ptr];
  for (genvar g = 0; g < N; g++) begin : g_lane
    npu_relu_lane #(.W(ACC_WIDTH)) u_relu (
      .relu (mode_q == 2'd2),
      .din  (head[g]),
      .dout (head_r[g])
    );
  end
  assign head_flat         = head_r;
  assign dma_data_out      = dma_data_out_valid ? head_flat[int'(out_beat)*AXI_WIDTH +: AXI_WIDTH] : '0;
  assign dma_data_out_last = dma_data_out_valid && (out_beat == OBW'(OUT_BEATS-1)) &&
                             (rows_drained == total_q - 32'd1);

  assign busy             = (state == S_FEED) || (state == S_DRAIN) || (state == S_FLUSH);
  assign done             = (state == S_DONE);
  assign core_valid_in    = {N{issue_q}};
  assign core_load_weight = load_q;
  assign core_x_in        = x_q;
  assign core_y_in        = '0;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = ((total_rows == 32'd0) || (mode == 2'd3)) ? S_DONE : S_FEED;
      S_FEED:  if (rows_fed == total_q) state_n = exec ? S_DRAIN : S_FLUSH;
      S_DRAIN: if (drained_n == total_q) state_n = S_DONE;
      S_FLUSH: if (flush_cnt == FW'(LOAD_FLUSH-1)) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort_act) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mode_q       <= '0;
      total_q      <= '0;
      rows_fed     <= '0;
      rows_drained <= '0;
      in_beat      <= '0;
      asm_q        <= '0;
      x_q          <= '0;
      issue_q      <= 1'b0;
      load_q       <= 1'b0;
      flush_cnt    <= '0;
      err          <= 1'b0;
    end else begin
      state     <= state_n;
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + 1'b1 : '0;
      issue_q   <= row_last && !abort_act;
      load_q    <= row_last && !abort_act && (mode_q == 2'd0);
      if (drop_err) err <= 1'b1;
      if (abort_act) begin
        rows_fed     <= '0;
        rows_drained <= '0;
        in_beat      <= '0;
      end else if (state == S_IDLE) begin
        if (start) begin
          mode_q       <= mode;
          total_q      <= total_rows;
          rows_fed     <= '0;
          rows_drained <= '0;
          in_beat      <= '0;
          err          <= (mode == 2'd3);
        end
      end else begin
        if (in_fire) begin
          asm_q   <= row_n;
          in_beat <= row_last ? '0 : in_beat + 1'b1;
        end
        if (row_last) begin
          x_q      <= row_n;
          rows_fed <= rows_fed + 32'd1;
        end
        if (pop) rows_drained <= rows_drained + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= core_y_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      out_beat <= '0;
      credits  <= CW'(RES_DEPTH);
    end else if (abort_act) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      out_beat <= '0;
      credits  <= CW'(RES_DEPTH);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (out_fire) out_beat <= pop ? '0 : out_beat + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({issue_dec, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end
endmodule

// File: tb/tb_npu_stream_sequencer.sv
// Scoreboard bench: directed jobs push expected output beats, a monitor pops and compares.
module tb_npu_stream_sequencer;
  localparam int N = 8, DW = 8, ACC = 32, AXI = 32, RD = 4, LF = 16;

  logic clk, rst_n, start, abort;
  logic [1:0] mode;
  logic [31:0] total_rows;
  logic busy, done, err;
  logic [AXI-1:0] dma_in, dma_out;
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic core_load_weight;
  logic [N-1:0] core_valid_in, core_valid_out;
  logic [N*DW-1:0] core_x_in;
  logic [N*ACC-1:0] core_y_in, core_y_out;

  npu_stream_sequencer #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(ACC), .AXI_WIDTH(AXI),
                         .RES_DEPTH(RD), .LOAD_FLUSH(LF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .total_rows(total_rows), .busy(busy), .done(done), .err(err),
    .dma_data_in(dma_in), .dma_data_in_valid(in_valid), .dma_data_in_ready(in_ready),
    .dma_data_out(dma_out), .dma_data_out_valid(out_valid), .dma_data_out_ready(out_ready),
    .dma_data_out_last(out_last), .core_load_weight(core_load_weight),
    .core_valid_in(core_valid_in), .core_x_in(core_x_in), .core_y_in(core_y_in),
    .core_y_out(core_y_out), .core_valid_out(core_valid_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // core model: fixed latency 10, each result lane is its input byte sign-extended
  logic [9:0] vp;
  logic [N*DW-1:0] xp [10];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) vp <= '0;
    else begin
      vp    <= {vp[8:0], core_valid_in[0] && !core_load_weight};
      xp[0] <= core_x_in;
      for (int i = 1; i < 10; i++) xp[i] <= xp[i-1];
    end
  end
  assign core_valid_out = {N{vp[9]}};
  always_comb begin
    core_y_out = '0;
    for (int i = 0; i < N; i++)
      core_y_out[i*ACC +: ACC] = {{(ACC-DW){xp[9][i*DW+DW-1]}}, xp[9][i*DW +: DW]};
  end

  int errors = 0, checks = 0;
  int issue_cnt = 0, load_cnt = 0, done_cnt = 0;
  realtime last_issue_t = 0;
  realtime xt [$];
  logic [32:0] exp_q [$];

  always @(negedge clk) begin
    if (core_valid_in[0]) begin issue_cnt <= issue_cnt + 1; last_issue_t <= $realtime; end
    if (core_load_weight) load_cnt <= load_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      xt.push_back($realtime);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat unexpected got=%h last=%0d", dma_out, out_last);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({out_last, dma_out} !== e) begin
          errors++;
          $display("FAIL out_beat got=%h last=%0d exp=%h last=%0d", dma_out, out_last, e[31:0], e[32]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input logic [1:0] m, input logic [31:0] tr);
    mode = m; total_rows = tr; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [AXI-1:0] d);
    bit r = 0;
    int t = 0;
    dma_in = d; in_valid = 1'b1;
    while (!r && t < 1000) begin
      @(negedge clk); r = in_ready;
      tick(); t++;
    end
    in_valid = 1'b0;
    if (!r) chk("in_accept", 64'(r), 64'd1);
  endtask

  task automatic send_row(input logic [63:0] row);
    send_beat(row[31:0]);
    send_beat(row[63:32]);
  endtask

  // row r carries bytes r*8+i, all positive, so result lane i is r*8+i
  function automatic logic [63:0] mkrow(input int r);
    logic [63:0] x;
    for (int i = 0; i < 8; i++) x[i*8 +: 8] = 8'(r*8 + i);
    return x;
  endfunction

  task automatic push_lanes(input logic [7:0][31:0] l, input bit last_row);
    for (int i = 0; i < 8; i++) exp_q.push_back({last_row && (i == 7), l[i]});
  endtask

  task automatic push_mk(input int r, input bit last_row);
    logic [7:0][31:0] l;
    for (int i = 0; i < 8; i++) l[i] = 32'(r*8 + i);
    push_lanes(l, last_row);
  endtask

  task automatic wait_done(output realtime td);
    int t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 3000);
    td = $realtime;
    chk("done_seen", 64'(done), 64'd1);
    tick();
  endtask

  realtime td;
  int b_iss, b_load, b_x, b_done;
  logic [7:0][31:0] relu_exp, raw_exp;

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst_n = 0; start = 0; abort = 0; mode = 0; total_rows = 0;
    dma_in = 0; in_valid = 0; out_ready = 0;
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out", 64'(dma_out), 0);
    chk("rst_core_v", 64'(core_valid_in), 0);
    chk("rst_core_x", 64'(core_x_in), 0);
    repeat (3) tick();
    rst_n = 1;
    tick();

    // execute, 3 rows, sink always ready
    out_ready = 1; b_x = xt.size(); b_load = load_cnt;
    start_job(2'd1, 3);
    for (int r = 0; r < 3; r++) push_mk(r, r == 2);
    for (int r = 0; r < 3; r++) send_row(mkrow(r));
    wait_done(td);
    chk("exe_beats", 64'(xt.size() - b_x), 24);
    if (xt.size() - b_x == 24) begin
      chk("exe_back2back", 64'(int'((xt[b_x+23] - xt[b_x]) / 10)), 23);
      chk("exe_done_lat", 64'(int'((td - xt[b_x+23]) / 10)), 1);
    end
    chk("exe_err", 64'(err), 0);
    chk("exe_no_load", 64'(load_cnt - b_load), 0);

    // weight load, 4 rows of 2 beats
    b_iss = issue_cnt; b_load = load_cnt; b_x = xt.size();
    start_job(2'd0, 4);
    for (int r = 0; r < 4; r++) send_row(mkrow(20 + r));
    wait_done(td);
    chk("ld_issues", 64'(issue_cnt - b_iss), 4);
    chk("ld_loads", 64'(load_cnt - b_load), 4);
    chk("ld_flush_lat", 64'(int'((td - last_issue_t) / 10)), LF + 1);
    chk("ld_no_out", 64'(xt.size() - b_x), 0);
    chk("ld_err", 64'(err), 0);

    // ReLU then raw on bytes {FB,07,80,01,00,7F,FF,10}
    relu_exp = {32'h10, 32'h0, 32'h7F, 32'h0, 32'h1, 32'h0, 32'h7, 32'h0};
    raw_exp  = {32'h10, 32'hFFFFFFFF, 32'h7F, 32'h0, 32'h1, 32'hFFFFFF80, 32'h7, 32'hFFFFFFFB};
    start_job(2'd2, 1);
    push_lanes(relu_exp, 1);
    send_row(64'h10FF7F00_018007FB);
    wait_done(td);
    start_job(2'd1, 1);
    push_lanes(raw_exp, 1);
    send_row(64'h10FF7F00_018007FB);
    wait_done(td);
    chk("relu_err", 64'(err), 0);

    // credit throttle: sink stalled, only RD rows may be in flight
    out_ready = 0; b_iss = issue_cnt; b_x = xt.size();
    start_job(2'd1, 10);
    for (int r = 0; r < 10; r++) push_mk(r, r == 9);
    fork
      for (int r = 0; r < 10; r++) send_row(mkrow(r));
      begin
        repeat (200) tick();
        chk("cr_issues", 64'(issue_cnt - b_iss), RD);
        chk("cr_in_ready", 64'(in_ready), 0);
        chk("cr_err", 64'(err), 0);
        chk("cr_out_valid", 64'(out_valid), 1);
        out_ready = 1;
      end
    join
    wait_done(td);
    chk("cr_beats", 64'(xt.size() - b_x), 80);
    chk("cr_err_end", 64'(err), 0);

    // zero rows, reserved mode, start while busy
    start_job(2'd1, 0);
    @(negedge clk);
    chk("z_done", 64'(done), 1);
    chk("z_err", 64'(err), 0);
    tick();
    start_job(2'd3, 5);
    @(negedge clk);
    chk("m3_done", 64'(done), 1);
    chk("m3_err", 64'(err), 1);
    tick();
    start_job(2'd1, 1);
    chk("sb_err_clr", 64'(err), 0);
    push_mk(5, 1);
    send_beat(mkrow(5)[31:0]);
    start_job(2'd3, 0);
    send_beat(mkrow(5)[63:32]);
    wait_done(td);
    chk("sb_err", 64'(err), 0);
    chk("sb_q_empty", 64'(exp_q.size()), 0);

    // abort with a row parked in the stalled result buffer
    out_ready = 0; b_x = xt.size();
    start_job(2'd1, 5);
    send_row(mkrow(0));
    repeat (15) tick();
    chk("ab_pre_valid", 64'(out_valid), 1);
    send_beat(mkrow(1)[31:0]);
    abort = 1;
    tick();
    abort = 0;
    b_done = done_cnt;
    @(negedge clk);
    chk("ab_busy", 64'(busy), 0);
    chk("ab_out_valid", 64'(out_valid), 0);
    tick();
    out_ready = 1;
    repeat (40) tick();
    chk("ab_no_done", 64'(done_cnt - b_done), 0);
    chk("ab_no_beats", 64'(xt.size() - b_x), 0);
    chk("ab_err", 64'(err), 0);
    start_job(2'd1, 2);
    push_mk(3, 0); push_mk(4, 1);
    send_row(mkrow(3)); send_row(mkrow(4));
    wait_done(td);
    chk("ab_new_beats", 64'(xt.size() - b_x), 16);
    chk("ab_new_err", 64'(err), 0);

    repeat (5) tick();
    chk("q_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/npu_stream_sequencer.md
Name: npu_stream_sequencer

Overview:
- Parametrised successor to the single-beat NPU sequencer. Sits between the DMA streaming ports and the NxN systolic core.
- Packs one or more input AXI beats into one core row and unpacks each result row into several output beats.
- Throttles the core with credits, so the result buffer can never overflow.
- Adds a ReLU execution mode, an end-of-stream `last` flag, abort, a deterministic `done` (no timeout counter) and a sticky error flag.

Parameters:
- N, 8, core rows/columns.
- DATA_WIDTH, 8, activation/weight element width.
- ACC_WIDTH, 32, accumulator width.
- AXI_WIDTH, 64, DMA beat width. N*DATA_WIDTH and N*ACC_WIDTH must both be integer multiples of AXI_WIDTH.
- RES_DEPTH, 32, result FIFO depth in rows (power of two).
- LOAD_FLUSH, 16, cycles to wait after the last weight row before `done`.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin job (sampled in IDLE only)
- abort  in  1  synchronous job cancel
- mode  in  2  0 = weight load, 1 = execute, 2 = execute+ReLU, 3 = reserved
- total_rows  in  32  core rows in job
- busy  out  1  job active
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag (cleared on start)
- dma_data_in  in  AXI_WIDTH  input beat
- dma_data_in_valid  in  1  input beat valid
- dma_data_in_ready  out  1  input beat accepted
- dma_data_out  out  AXI_WIDTH  result beat
- dma_data_out_valid  out  1  result beat valid
- dma_data_out_ready  in  1  result beat sink ready
- dma_data_out_last  out  1  final beat of job
- core_load_weight  out  1  weight-load strobe
- core_valid_in  out  N  row valid per lane
- core_x_in  out  N*DATA_WIDTH  packed row to core
- core_y_in  out  N*ACC_WIDTH  tied to zero
- core_y_out  in  N*ACC_WIDTH  result row from core
- core_valid_out  in  N  result lane valids

Behaviour:
- Clocking/reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; FIFO empty; credits = RES_DEPTH; FSM in IDLE.
- Derived constants: IN_BEATS = N*DATA_WIDTH/AXI_WIDTH. OUT_BEATS = N*ACC_WIDTH/AXI_WIDTH.
- FSM states: IDLE, FEED, DRAIN, FLUSH, DONE.
- IDLE: on start, latch mode and total_rows, set busy, clear err.
  - total_rows==0 -> DONE.
  - mode==3 -> set err, go to DONE.
  - Otherwise -> FEED.
  - start while busy is ignored.
- Input handshake: beat transfers when valid && ready.
  - dma_data_in_ready=1 only in FEED, while rows_fed<total_rows and (mode==0 or credits>0).
  - Beat k of a row fills core_x_in[k*AXI_WIDTH +: AXI_WIDTH], starting at k=0.
- Row issue: on the cycle after the last beat of a row is accepted:
  - core_valid_in = all ones for exactly 1 cycle; otherwise 0.
  - core_load_weight = (mode==0) in that same cycle; otherwise 0.
  - core_x_in holds its value until the next row is issued.
  - In execute modes, credits decrement at issue.
- FEED exits:
  - rows_fed==total_rows and mode==0 -> FLUSH.
  - rows_fed==total_rows and execute mode -> DRAIN.
- Result capture: when &core_valid_out, push core_y_out into the result FIFO, execute modes only.
  - Push with a full FIFO, or any core_valid_out while in mode 0: drop the data and set err.
- Output unpack: beat j = row[j*AXI_WIDTH +: AXI_WIDTH], j = 0..OUT_BEATS-1.
  - Mode 2: each ACC_WIDTH lane is clamped to 0 when its MSB is 1.
  - Valid/ready rule: data and last stay stable while valid && !ready.
  - At most one beat transfers per cycle, with no bubble between beats or rows.
  - Popping a row (its last beat transferred) increments credits and rows_drained.
  - dma_data_out_last=1 only on beat OUT_BEATS-1 of row total_rows-1.
- DRAIN: rows_drained==total_rows -> DONE.
- FLUSH: wait LOAD_FLUSH cycles -> DONE.
- DONE: done=1 and busy=0 in the same cycle, then -> IDLE.
- Credits: always 0..RES_DEPTH; they cover rows in the core pipeline plus rows in the FIFO.
- Simultaneous events:
  - Credit return and row issue in the same cycle leave credits unchanged.
  - FIFO push and pop in the same cycle leave the count unchanged.
- abort (any state except IDLE): next cycle the FSM is IDLE, busy=0, FIFO flushed, credits reset, out_valid=0, done not pulsed. Core results that arrive later are dropped silently (no err).
- Asynchronous reset mid-job: everything returns to reset values immediately.

Test Plan:
- Defaults, mode=1, total_rows=3, core model of fixed latency 10, ready held 1 -> 12 output beats back-to-back, last only on beat 12, done one cycle after the final transfer, err=0.
- N=16, DATA_WIDTH=8 (IN_BEATS=2), mode=0, total_rows=16 -> 32 input beats accepted, core_load_weight and core_valid_in pulsed 16 times, done exactly LOAD_FLUSH+1 cycles after the last issue, no output beats.
- mode=2, core returns lanes {-5, 7, 0x80000000, 1, …} -> output lanes {0, 7, 0, 1, …}; mode=1 with the same rows -> raw values passed through.
- RES_DEPTH=4, total_rows=10, dma_data_out_ready=0 for 200 cycles -> exactly 4 rows issued, in_ready low, no err; release ready -> all 40 beats delivered in order.
- total_rows=0 -> done one cycle after start; mode=3 -> err=1 plus done; start pulsed while busy -> ignored.
- abort pulsed during row 2 of 5 with out_valid stalled -> busy=0 next cycle, no done, no further beats; a new job started afterwards completes correctly.
